// File: rtl/rps_match_scorer_if.sv
// Computer-player handshake: the source holds com_choice with com_valid until the registered com_ack.
// The master drives the choice and valid; the slave (the scorer) returns the ack.
interface rps_match_scorer_if;
  logic [1:0] com_choice;
  logic       com_valid;
  logic       com_ack;

  modport master (output com_choice, output com_valid, input com_ack);
  modport slave  (input com_choice, input com_valid, output com_ack);
endinterface

// File: rtl/rps_match_scorer.sv
// Rock-paper-scissors round judge and match scorer; play edge -> WAIT_COM next cycle, valid at M -> ack/JUDGE at M+1, results at M+2.
// The computer source is held off by a registered ack; play edges outside IDLE are dropped, and clear_match overrides everything.
module rps_match_scorer #(
  parameter int SCORE_W     = 8,
  parameter int ROUND_W     = 8,
  parameter int WIN_TARGET  = 0,
  parameter int SATURATE    = 1,
  parameter int COM_TIMEOUT = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_play_req,
  input  logic                 i_clear_match,
  input  logic [1:0]           i_user_choice,
  rps_match_scorer_if.slave    com_if,
  output logic                 o_busy,
  output logic [1:0]           o_user_loaded,
  output logic [1:0]           o_com_loaded,
  output logic                 o_uwin,
  output logic                 o_cwin,
  output logic                 o_equ,
  output logic [SCORE_W-1:0]   o_user_score,
  output logic [SCORE_W-1:0]   o_com_score,
  output logic [SCORE_W-1:0]   o_draw_count,
  output logic [ROUND_W-1:0]   o_round_count,
  output logic                 o_match_over,
  output logic [1:0]           o_match_winner,
  output logic                 o_err_invalid,
  output logic                 o_err_timeout
);

  localparam int CTR_W = $clog2(COM_TIMEOUT + 1);
  localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(WIN_TARGET);
  localparam logic [CTR_W-1:0]   CTR_LAST = CTR_W'(COM_TIMEOUT - 1);
  localparam logic [1:0] CH_INVALID = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_COM, S_JUDGE, S_MATCH_OVER} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_play_d;
  logic [CTR_W-1:0]     r_ctr, w_ctr_nxt;
  logic [1:0]           r_user_sel, w_user_sel_nxt;
  logic [1:0]           r_com_sel, w_com_sel_nxt;
  logic                 r_com_ack, w_com_ack_nxt;
  logic [1:0]           r_user_loaded, w_user_loaded_nxt;
  logic [1:0]           r_com_loaded, w_com_loaded_nxt;
  logic                 r_uwin, w_uwin_nxt;
  logic                 r_cwin, w_cwin_nxt;
  logic                 r_equ, w_equ_nxt;
  logic [SCORE_W-1:0]   r_user_score, w_user_score_nxt;
  logic [SCORE_W-1:0]   r_com_score, w_com_score_nxt;
  logic [SCORE_W-1:0]   r_draw_count, w_draw_count_nxt;
  logic [ROUND_W-1:0]   r_round_count, w_round_count_nxt;
  logic [1:0]           r_match_winner, w_match_winner_nxt;
  logic                 r_err_invalid, w_err_invalid_nxt;
  logic                 r_err_timeout, w_err_timeout_nxt;
  logic                 w_play_edge;
  logic                 w_user_beats;

  function automatic logic [SCORE_W-1:0] f_bump(input logic [SCORE_W-1:0] v);
    if ((SATURATE != 0) && (&v)) return v;
    return v + SCORE_W'(1);
  endfunction

  assign w_play_edge  = i_play_req & ~r_play_d;
  assign w_user_beats = ((r_user_sel == 2'b00) && (r_com_sel == 2'b01)) ||
                        ((r_user_sel == 2'b01) && (r_com_sel == 2'b10)) ||
                        ((r_user_sel == 2'b10) && (r_com_sel == 2'b00));

  always_comb begin
    w_state_nxt        = r_state;
    w_ctr_nxt          = r_ctr;
    w_user_sel_nxt     = r_user_sel;
    w_com_sel_nxt      = r_com_sel;
    w_com_ack_nxt      = 1'b0;
    w_user_loaded_nxt  = r_user_loaded;
    w_com_loaded_nxt   = r_com_loaded;
    w_uwin_nxt         = r_uwin;
    w_cwin_nxt         = r_cwin;
    w_equ_nxt          = r_equ;
    w_user_score_nxt   = r_user_score;
    w_com_score_nxt    = r_com_score;
    w_draw_count_nxt   = r_draw_count;
    w_round_count_nxt  = r_round_count;
    w_match_winner_nxt = r_match_winner;
    w_err_invalid_nxt  = 1'b0;
    w_err_timeout_nxt  = 1'b0;

    if (i_clear_match) begin
      w_state_nxt        = S_IDLE;
      w_ctr_nxt          = '0;
      w_user_sel_nxt     = '0;
      w_com_sel_nxt      = '0;
      w_user_loaded_nxt  = '0;
      w_com_loaded_nxt   = '0;
      w_uwin_nxt         = 1'b0;
      w_cwin_nxt         = 1'b0;
      w_equ_nxt          = 1'b0;
      w_user_score_nxt   = '0;
      w_com_score_nxt    = '0;
      w_draw_count_nxt   = '0;
      w_round_count_nxt  = '0;
      w_match_winner_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_play_edge) begin
            w_user_sel_nxt = i_user_choice;
            if (i_user_choice == CH_INVALID) begin
              w_err_invalid_nxt = 1'b1;
            end else begin
              w_ctr_nxt   = '0;
              w_state_nxt = S_WAIT_COM;
            end
          end
        end
        S_WAIT_COM: begin
          if (com_if.com_valid) begin
            w_com_ack_nxt = 1'b1;
            w_com_sel_nxt = com_if.com_choice;
            if (com_if.com_choice == CH_INVALID) begin
              w_err_invalid_nxt = 1'b1;
              w_state_nxt       = S_IDLE;
            end else begin
              w_state_nxt = S_JUDGE;
            end
          end else if (r_ctr == CTR_LAST) begin
            w_err_timeout_nxt = 1'b1;
            w_state_nxt       = S_IDLE;
          end else begin
            w_ctr_nxt = r_ctr + CTR_W'(1);
          end
        end
        S_JUDGE: begin
          w_user_loaded_nxt = r_user_sel;
          w_com_loaded_nxt  = r_com_sel;
          w_uwin_nxt        = 1'b0;
          w_cwin_nxt        = 1'b0;
          w_equ_nxt         = 1'b0;
          if (r_user_sel == r_com_sel) begin
            w_equ_nxt        = 1'b1;
            w_draw_count_nxt = f_bump(r_draw_count);
          end else if (w_user_beats) begin
            w_uwin_nxt       = 1'b1;
            w_user_score_nxt = f_bump(r_user_score);
          end else begin
            w_cwin_nxt      = 1'b1;
            w_com_score_nxt = f_bump(r_com_score);
          end
          w_round_count_nxt = r_round_count + ROUND_W'(1);
          w_state_nxt       = S_IDLE;
          // Only one score moves per round, so at most one side can hit the target here.
          if (WIN_TARGET != 0) begin
            if (w_user_score_nxt == TARGET) begin
              w_state_nxt        = S_MATCH_OVER;
              w_match_winner_nxt = 2'b01;
            end else if (w_com_score_nxt == TARGET) begin
              w_state_nxt        = S_MATCH_OVER;
              w_match_winner_nxt = 2'b10;
            end
          end
        end
        S_MATCH_OVER: w_state_nxt = S_MATCH_OVER;
        default:      w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_play_d       <= 1'b0;
      r_ctr          <= '0;
      r_user_sel     <= '0;
      r_com_sel      <= '0;
      r_com_ack      <= 1'b0;
      r_user_loaded  <= '0;
      r_com_loaded   <= '0;
      r_uwin         <= 1'b0;
      r_cwin         <= 1'b0;
      r_equ          <= 1'b0;
      r_user_score   <= '0;
      r_com_score    <= '0;
      r_draw_count   <= '0;
      r_round_count  <= '0;
      r_match_winner <= '0;
      r_err_invalid  <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_play_d       <= i_play_req;
      r_ctr          <= w_ctr_nxt;
      r_user_sel     <= w_user_sel_nxt;
      r_com_sel      <= w_com_sel_nxt;
      r_com_ack      <= w_com_ack_nxt;
      r_user_loaded  <= w_user_loaded_nxt;
      r_com_loaded   <= w_com_loaded_nxt;
      r_uwin         <= w_uwin_nxt;
      r_cwin         <= w_cwin_nxt;
      r_equ          <= w_equ_nxt;
      r_user_score   <= w_user_score_nxt;
      r_com_score    <= w_com_score_nxt;
      r_draw_count   <= w_draw_count_nxt;
      r_round_count  <= w_round_count_nxt;
      r_match_winner <= w_match_winner_nxt;
      r_err_invalid  <= w_err_invalid_nxt;
      r_err_timeout  <= w_err_timeout_nxt;
    end
  end

  assign com_if.com_ack = r_com_ack;
  assign o_busy         = (r_state == S_WAIT_COM) || (r_state == S_JUDGE);
  assign o_match_over   = (r_state == S_MATCH_OVER);
  assign o_user_loaded  = r_user_loaded;
  assign o_com_loaded   = r_com_loaded;
  assign o_uwin         = r_uwin;
  assign o_cwin         = r_cwin;
  assign o_equ          = r_equ;
  assign o_user_score   = r_user_score;
  assign o_com_score    = r_com_score;
  assign o_draw_count   = r_draw_count;
  assign o_round_count  = r_round_count;
  assign o_match_winner = r_match_winner;
  assign o_err_invalid  = r_err_invalid;
  assign o_err_timeout  = r_err_timeout;

endmodule

// File: tb/tb_rps_match_scorer.sv
// Directed bench for rps_match_scorer: four instances (default, first-to-3, 2-bit saturating, 2-bit wrapping)
// share stimulus; play_req reaches only the instance selected by sel.
module tb_rps_match_scorer;

  logic       clk = 1'b0;
  logic       rst;
  logic       play_req;
  logic       clear_match;
  logic [1:0] user_choice;
  logic [1:0] com_choice;
  logic       com_valid;
  int         sel;
  int         n_checks = 0;
  int         n_errors = 0;

  logic       ack [4];
  logic       busy [4];
  logic       uwin [4];
  logic       cwin [4];
  logic       equ [4];
  logic       mo [4];
  logic       errinv [4];
  logic       errto [4];
  logic [1:0] ul [4];
  logic [1:0] cl [4];
  logic [1:0] mw [4];
  logic [7:0] us [4];
  logic [7:0] cs [4];
  logic [7:0] dc [4];
  logic [7:0] rc [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int SW = (g >= 2) ? 2 : 8;
    rps_match_scorer_if cif();
    logic          l_play;
    logic [SW-1:0] l_us, l_cs, l_dc;
    assign l_play         = play_req && (sel == g);
    assign cif.com_valid  = com_valid;
    assign cif.com_choice = com_choice;
    assign ack[g]         = cif.com_ack;
    assign us[g]          = 8'(l_us);
    assign cs[g]          = 8'(l_cs);
    assign dc[g]          = 8'(l_dc);

    rps_match_scorer #(
      .SCORE_W(SW), .ROUND_W(8), .WIN_TARGET((g == 1) ? 3 : 0),
      .SATURATE((g == 3) ? 0 : 1), .COM_TIMEOUT(4)
    ) dut (
      .i_clk(clk), .i_rst(rst), .i_play_req(l_play), .i_clear_match(clear_match),
      .i_user_choice(user_choice), .com_if(cif),
      .o_busy(busy[g]), .o_user_loaded(ul[g]), .o_com_loaded(cl[g]),
      .o_uwin(uwin[g]), .o_cwin(cwin[g]), .o_equ(equ[g]),
      .o_user_score(l_us), .o_com_score(l_cs), .o_draw_count(l_dc),
      .o_round_count(rc[g]), .o_match_over(mo[g]), .o_match_winner(mw[g]),
      .o_err_invalid(errinv[g]), .o_err_timeout(errto[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (sel=%0d, t=%0t)", tag, act, exp, sel, $time);
    end
  endtask

  // Plays one round on the selected instance; returns on the cycle its results should be visible.
  task automatic play_round(input logic [1:0] u, input logic [1:0] c, output logic inv_at_ack);
    int lat;
    @(negedge clk);
    play_req = 1'b1; user_choice = u;
    @(negedge clk);
    play_req = 1'b0; com_valid = 1'b1; com_choice = c;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack[sel] && lat < 8);
    inv_at_ack = errinv[sel];
    com_valid = 1'b0;
    check("ack_latency", lat, 1);
    @(negedge clk);
    check("ack_pulse_1cyc", ack[sel], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic inv;
    int   cnt;
    rst = 1'b1; play_req = 1'b0; clear_match = 1'b0;
    user_choice = 2'b00; com_choice = 2'b00; com_valid = 1'b0; sel = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy[0], 1'b0);
    check("rst_user_score", us[0], 0);
    check("rst_round_count", rc[0], 0);
    check("rst_flags", {uwin[0], cwin[0], equ[0], mo[0], ack[0]}, 0);
    check("rst_winner", mw[1], 0);
    rst = 1'b0;

    // Basic user win, then a draw and a computer win
    play_round(2'b00, 2'b01, inv);
    check("t1_flags", {uwin[0], cwin[0], equ[0]}, 3'b100);
    check("t1_user_score", us[0], 1);
    check("t1_round_count", rc[0], 1);
    check("t1_loaded", {ul[0], cl[0]}, 4'b0001);
    check("t1_busy", busy[0], 1'b0);
    play_round(2'b01, 2'b01, inv);
    check("t2_draw_flags", {uwin[0], cwin[0], equ[0]}, 3'b001);
    check("t2_draw_count", dc[0], 1);
    play_round(2'b10, 2'b01, inv);
    check("t2_cwin_flags", {uwin[0], cwin[0], equ[0]}, 3'b010);
    check("t2_com_score", cs[0], 1);
    check("t2_round_count", rc[0], 3);
    check("t2_user_score", us[0], 1);

    // Invalid user choice
    @(negedge clk);
    play_req = 1'b1; user_choice = 2'b11;
    @(negedge clk);
    play_req = 1'b0;
    check("t3_user_inv_pulse", errinv[0], 1'b1);
    check("t3_user_inv_busy", busy[0], 1'b0);
    @(negedge clk);
    check("t3_user_inv_end", errinv[0], 1'b0);
    check("t3_user_inv_rounds", rc[0], 3);

    // Invalid computer choice is still acked
    play_round(2'b00, 2'b11, inv);
    check("t3_com_inv_pulse", inv, 1'b1);
    check("t3_com_inv_busy", busy[0], 1'b0);
    check("t3_com_inv_rounds", rc[0], 3);
    check("t3_com_inv_flags", {uwin[0], cwin[0], equ[0]}, 3'b010);

    // Timeout after exactly four WAIT_COM cycles
    @(negedge clk);
    play_req = 1'b1; user_choice = 2'b00;
    @(negedge clk);
    play_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (errto[0]) break;
      if (busy[0]) cnt++;
      @(negedge clk);
    end
    check("t4_wait_cycles", cnt, 4);
    check("t4_timeout_pulse", errto[0], 1'b1);
    check("t4_busy", busy[0], 1'b0);
    check("t4_scores", {us[0], cs[0], rc[0]}, {8'd1, 8'd1, 8'd3});
    @(negedge clk);
    check("t4_timeout_end", errto[0], 1'b0);

    // clear_match beats a same-cycle play edge
    clear_match = 1'b1; play_req = 1'b1; user_choice = 2'b00;
    @(negedge clk);
    clear_match = 1'b0; play_req = 1'b0;
    check("clr_busy", busy[0], 1'b0);
    check("clr_counts", {us[0], cs[0], dc[0], rc[0]}, 0);
    check("clr_flags", {uwin[0], cwin[0], equ[0], ul[0], cl[0]}, 0);

    // First-to-3 match
    sel = 1;
    play_round(2'b00, 2'b01, inv);
    play_round(2'b01, 2'b10, inv);
    check("t5_not_over", mo[1], 1'b0);
    play_round(2'b10, 2'b00, inv);
    check("t5_match_over", mo[1], 1'b1);
    check("t5_winner", mw[1], 2'b01);
    check("t5_user_score", us[1], 3);
    @(negedge clk);
    play_req = 1'b1; user_choice = 2'b00;
    @(negedge clk);
    play_req = 1'b0; com_valid = 1'b1; com_choice = 2'b01;
    @(negedge clk);
    check("t5_ignored_ack", ack[1], 1'b0);
    check("t5_ignored_busy", busy[1], 1'b0);
    check("t5_held", {mo[1], us[1], rc[1]}, {1'b1, 8'd3, 8'd3});
    com_valid = 1'b0;
    clear_match = 1'b1;
    @(negedge clk);
    clear_match = 1'b0;
    check("t5_clear_over", {mo[1], mw[1]}, 0);
    check("t5_clear_counts", {us[1], rc[1], ul[1], cl[1], uwin[1]}, 0);

    // 2-bit scores: saturate vs wrap
    sel = 2;
    for (int i = 0; i < 5; i++) play_round(2'b00, 2'b01, inv);
    check("t6_sat_score", us[2], 3);
    check("t6_sat_rounds", rc[2], 5);
    sel = 3;
    for (int i = 0; i < 5; i++) play_round(2'b01, 2'b10, inv);
    check("t6_wrap_score", us[3], 1);
    check("t6_wrap_rounds", rc[3], 5);

    // Asynchronous reset while waiting for the computer
    @(negedge clk);
    play_req = 1'b1; user_choice = 2'b00;
    @(negedge clk);
    play_req = 1'b0;
    check("t6_waiting", busy[3], 1'b1);
    rst = 1'b1;
    #1;
    check("t6_rst_busy", busy[3], 1'b0);
    check("t6_rst_counts", {us[3], rc[3], us[2]}, 0);
    check("t6_rst_flags", {uwin[3], ul[3], cl[3]}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
